// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel deserializer with a one-word output holding register.
// Word valid 1 cycle after its last bit; serial side stalls only when a word would complete into a full output.
module serial_to_parallel #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             serial_ready,
  output logic             busy,
  output logic             parallel_valid,
  output logic [width-1:0] parallel_data,
  input  logic             parallel_ready
);

  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(width - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-2:0] asm_q, asm_d;
  logic             pvld_q, pvld_d;
  logic [width-1:0] pdat_q, pdat_d;

  logic at_last;
  logic bit_acc;
  logic word_done;
  logic word_xfer;

  // Ready and busy come from registered state only, so there is no
  // combinational path from parallel_ready back to the serial side.
  assign at_last      = (cnt_q == LAST_IDX);
  assign serial_ready = !(at_last && pvld_q);
  assign busy         = (cnt_q != '0);

  assign bit_acc   = serial_valid && serial_ready;
  assign word_done = bit_acc && at_last;
  assign word_xfer = pvld_q && parallel_ready;

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (bit_acc) begin
      if (at_last) begin
        cnt_d = '0;
        asm_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int k = 0; k < width - 1; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            asm_d[k] = serial_data;
          end
        end
      end
    end
  end

  // The final bit bypasses the assembly register straight into the output word.
  always_comb begin
    pvld_d = pvld_q;
    pdat_d = pdat_q;
    if (word_done) begin
      pvld_d = 1'b1;
      pdat_d = {serial_data, asm_q};
    end else if (word_xfer) begin
      pvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      pvld_q <= 1'b0;
      pdat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      pvld_q <= pvld_d;
      pdat_q <= pdat_d;
    end
  end

  assign parallel_valid = pvld_q;
  assign parallel_data  = pdat_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel at width 8 and width 3.
// Stimulus feeds a bit-queue reference model; negedge monitors pop and compare words.
module tb_serial_to_parallel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sv8, sd8, pr8, sr8, busy8, pv8;
  logic [7:0] pd8;
  logic       sv3, sd3, pr3, sr3, busy3, pv3;
  logic [2:0] pd3;

  serial_to_parallel #(.width(8)) u8 (
    .clk(clk), .rst(rst),
    .serial_valid(sv8), .serial_data(sd8), .serial_ready(sr8), .busy(busy8),
    .parallel_valid(pv8), .parallel_data(pd8), .parallel_ready(pr8)
  );

  serial_to_parallel #(.width(3)) u3 (
    .clk(clk), .rst(rst),
    .serial_valid(sv3), .serial_data(sd3), .serial_ready(sr3), .busy(busy3),
    .parallel_valid(pv3), .parallel_data(pd3), .parallel_ready(pr3)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int stall8 = 0;
  bit rnd_on = 1'b0;

  bit bits8[$];
  bit bits3[$];
  int exp8[$];
  int exp3[$];
  int pop_cyc8[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: a word is the sum of its bits weighted by arrival order.
  function automatic int pack_bits(input bit q[$]);
    int w = 0;
    foreach (q[i]) if (q[i]) w += (1 << i);
    return w;
  endfunction

  task automatic accept8(input bit b);
    bits8.push_back(b);
    if (bits8.size() == 8) begin
      exp8.push_back(pack_bits(bits8));
      bits8.delete();
    end
  endtask

  task automatic accept3(input bit b);
    bits3.push_back(b);
    if (bits3.size() == 3) begin
      exp3.push_back(pack_bits(bits3));
      bits3.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) begin
      pr8 = 1'($urandom_range(0, 1));
      pr3 = 1'($urandom_range(0, 1));
    end
  endtask

  // Callers are aligned just after a posedge; a bit is accepted on the
  // first posedge at which serial_ready is seen high.
  task automatic send8(input bit b);
    int  waited = 0;
    bit  ok = 1'b0;
    sv8 = 1'b1;
    sd8 = b;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (sr8) ok = 1'b1;
      else begin
        stall8++;
        waited++;
        tick();
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send8_timeout: serial_ready stayed %0b for %0d cycles, required 1", sr8, waited);
      sv8 = 1'b0;
    end else begin
      @(posedge clk);
      accept8(b);
      #1;
      sv8 = 1'b0;
      if (rnd_on) begin
        pr8 = 1'($urandom_range(0, 1));
        pr3 = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic send3(input bit b);
    int  waited = 0;
    bit  ok = 1'b0;
    sv3 = 1'b1;
    sd3 = b;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (sr3) ok = 1'b1;
      else begin
        waited++;
        tick();
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send3_timeout: serial_ready stayed %0b for %0d cycles, required 1", sr3, waited);
      sv3 = 1'b0;
    end else begin
      @(posedge clk);
      accept3(b);
      #1;
      sv3 = 1'b0;
      if (rnd_on) begin
        pr8 = 1'($urandom_range(0, 1));
        pr3 = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic send_word8(input logic [7:0] w, input int gap_max);
    for (int k = 0; k < 8; k++) begin
      send8(w[k]);
      if (gap_max > 0) repeat ($urandom_range(1, gap_max)) tick();
    end
  endtask

  // Monitor for the width-8 instance.
  initial begin : mon8
    bit         held = 1'b0;
    logic [7:0] hdat = '0;
    forever begin
      @(negedge clk);
      if (!rst) held = 1'b0;
      else begin
        chk("busy8", int'(busy8), int'(bits8.size() != 0));
        if (held) begin
          chk("hold_vld8", int'(pv8), 1);
          chk("hold_dat8", int'(pd8), int'(hdat));
        end
        if (pv8 && pr8) begin
          if (exp8.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL word8: got unexpected word 0x%0h, required none", pd8);
          end else begin
            chk("word8", int'(pd8), exp8.pop_front());
            pop_cyc8.push_back(cyc);
          end
          held = 1'b0;
        end else if (pv8) begin
          held = 1'b1;
          hdat = pd8;
        end else held = 1'b0;
      end
    end
  end

  // Monitor for the width-3 instance.
  initial begin : mon3
    bit         held = 1'b0;
    logic [2:0] hdat = '0;
    forever begin
      @(negedge clk);
      if (!rst) held = 1'b0;
      else begin
        chk("busy3", int'(busy3), int'(bits3.size() != 0));
        if (held) begin
          chk("hold_vld3", int'(pv3), 1);
          chk("hold_dat3", int'(pd3), int'(hdat));
        end
        if (pv3 && pr3) begin
          if (exp3.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL word3: got unexpected word 0x%0h, required none", pd3);
          end else chk("word3", int'(pd3), exp3.pop_front());
          held = 1'b0;
        end else if (pv3) begin
          held = 1'b1;
          hdat = pd3;
        end else held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] c3;
    int         s0;
    bit         seq3[6];
    rst = 1'b0;
    sv8 = 1'b0; sd8 = 1'b0; pr8 = 1'b1;
    sv3 = 1'b0; sd3 = 1'b0; pr3 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld", int'(pv8), 0);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_srdy", int'(sr8), 1);
    chk("rst_dat", int'(pd8), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 0xA5 contiguous: single-cycle valid pulse one cycle after bit 8
    send_word8(8'hA5, 0);
    @(negedge clk);
    chk("a5_vld", int'(pv8), 1);
    chk("a5_dat", int'(pd8), 'hA5);
    chk("a5_busy_after", int'(busy8), 0);
    @(negedge clk);
    chk("a5_pulse_width", int'(pv8), 0);
    tick();

    // 0x3C with gaps
    send_word8(8'h3C, 3);
    @(negedge clk);
    chk("3c_gap_dat", int'(pd8), 'h3C);
    tick();

    // Stall: 0x3C held, 7 bits of 0xC3 fill the assembler
    pr8 = 1'b0;
    c3 = 8'hC3;
    send_word8(8'h3C, 0);
    for (int k = 0; k < 7; k++) send8(c3[k]);
    @(negedge clk);
    chk("stall_srdy", int'(sr8), 0);
    chk("stall_vld", int'(pv8), 1);
    chk("stall_dat", int'(pd8), 'h3C);
    repeat (3) tick();
    pr8 = 1'b1;
    @(negedge clk);
    chk("drain_srdy", int'(sr8), 0);
    tick();
    pr8 = 1'b0;
    @(negedge clk);
    chk("bubble_srdy", int'(sr8), 1);
    chk("bubble_vld", int'(pv8), 0);
    tick();
    send8(c3[7]);
    @(negedge clk);
    chk("c3_vld", int'(pv8), 1);
    chk("c3_dat", int'(pd8), 'hC3);
    tick();
    pr8 = 1'b1;
    repeat (2) tick();

    // Back-to-back 0x01, 0x80 with no stall
    pop_cyc8.delete();
    s0 = stall8;
    send_word8(8'h01, 0);
    send_word8(8'h80, 0);
    repeat (3) tick();
    chk("b2b_count", pop_cyc8.size(), 2);
    if (pop_cyc8.size() == 2) chk("b2b_spacing", pop_cyc8[1] - pop_cyc8[0], 8);
    chk("b2b_stalls", stall8 - s0, 0);

    // Asynchronous reset with a pending word and a partial word
    pr8 = 1'b0;
    send_word8(8'h55, 0);
    for (int k = 0; k < 5; k++) send8(1'b1);
    #1;
    rst = 1'b0;
    bits8.delete(); exp8.delete();
    bits3.delete(); exp3.delete();
    #1;
    chk("arst_vld", int'(pv8), 0);
    chk("arst_busy", int'(busy8), 0);
    chk("arst_srdy", int'(sr8), 1);
    chk("arst_dat", int'(pd8), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    pr8 = 1'b1;
    send_word8(8'h0F, 0);
    @(negedge clk);
    chk("post_rst_dat", int'(pd8), 'h0F);
    tick();

    // width=3 wrap
    seq3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pr3 = 1'b1;
    foreach (seq3[i]) send3(seq3[i]);
    @(negedge clk);
    chk("w3_vld", int'(pv3), 1);
    chk("w3_dat", int'(pd3), 3'b100);
    tick();

    // Randomized traffic with random backpressure and gaps
    rnd_on = 1'b1;
    for (int i = 0; i < 240; i++) begin
      send8(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    for (int i = 0; i < 90; i++) begin
      send3(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rnd_on = 1'b0;
    pr8 = 1'b1;
    pr3 = 1'b1;
    repeat (5) tick();
    chk("drain_exp8", exp8.size(), 0);
    chk("drain_exp3", exp3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Deserializer for the single-bit serial stream produced by the team's parallel-to-serial converter.
- Collects `width` serial bits, LSB first, into one parallel word.
- Presents the word on a valid/ready output interface, with a one-word holding register so the next word can be assembled while the consumer stalls.
- Sits between a serial link and any word-oriented consumer.

Parameters:
width  8  bits per parallel word; legal range >= 2

Ports:
clk             input   1      clock; all state updates on posedge
rst             input   1      reset, asynchronous assert, active-low (0 = reset)
serial_valid    input   1      serial_data carries a bit this cycle
serial_data     input   1      serial bit
serial_ready    output  1      block can accept a serial bit this cycle
busy            output  1      a partial word is being assembled (1..width-1 bits held)
parallel_valid  output  1      parallel_data holds a complete word
parallel_data   output  width  assembled word; bit 0 = first received bit
parallel_ready  input   1      consumer accepts the word this cycle

Behaviour:
- Reset (rst=0, asynchronous): bit counter=0, assembly register=0, parallel_valid=0, parallel_data=0. Outputs during and after reset: serial_ready=1, busy=0. Any partial word or pending output word is discarded, including one in mid-assembly.
- Bit acceptance: a bit is accepted on a posedge when serial_valid && serial_ready. Cycles with serial_valid=0 are gaps; gaps freeze assembly state indefinitely.
- Bit ordering: the k-th accepted bit of a word (k = 0..width-1) becomes parallel_data[k].
- Bit counter: $clog2(width) bits wide. Increments on each accepted bit. Wraps from width-1 to 0 on acceptance of the last bit of a word.
- busy = (counter != 0). It is a function of registered state only.
- Word completion: when bit width-1 is accepted, the full word loads into the output register on that same edge. parallel_valid=1 from the next cycle, so latency is 1 cycle after the last bit.
- Output handshake: a word transfers on a posedge with parallel_valid && parallel_ready. parallel_valid clears on that edge unless a new word completes on the same edge; in that case the new word loads and parallel_valid stays 1.
- While parallel_valid && !parallel_ready, parallel_data and parallel_valid are held stable.
- serial_ready = !(counter == width-1 && parallel_valid). It depends on registered state only, with no combinational path from parallel_ready. The block stalls only when a word would complete while the output register is occupied.
- Stall bubble: when serial_ready=0 and the word drains on that edge, serial_ready returns to 1 the next cycle. This one-cycle bubble is required behaviour.
- When the consumer keeps parallel_ready=1, back-to-back words stream with no stall: one word every `width` accepted bits.
- No data is ever lost or duplicated. Each accepted bit appears in exactly one output word.
- parallel_data retains the last word after transfer. Its value is don't-care while parallel_valid=0, but a reset still clears it to 0.

Test Plan:
- width=8, parallel_ready=1, 8 contiguous bits of 0xA5 (1,0,1,0,0,1,0,1) -> parallel_valid pulses for exactly 1 cycle, one cycle after the 8th bit; parallel_data=0xA5; busy=1 during bits 2..8 and 0 afterwards.
- width=8, bits of 0x3C with random gaps (serial_valid=0 for 1-3 cycles) -> parallel_data=0x3C; counter and busy hold during gaps.
- width=8, parallel_ready=0, send 0x3C then 7 bits of 0xC3:
  - 0x3C is held stable on the output and serial_ready falls to 0.
  - Raise parallel_ready for 1 cycle -> 0x3C transfers and serial_ready returns to 1 the next cycle.
  - The 8th bit is then accepted -> parallel_data=0xC3.
- width=8, parallel_ready=1, words 0x01 then 0x80 back-to-back with no gaps -> two single-cycle parallel_valid pulses 8 cycles apart; serial_ready stays 1 throughout.
- Assert rst=0 asynchronously after 5 bits of 0xFF, with a word 0x55 pending unaccepted:
  - Required immediately: parallel_valid=0, busy=0, serial_ready=1, parallel_data=0.
  - Then send 8 bits of 0x0F -> output 0x0F, with no stale bits from before reset.
- width=3, parallel_ready=1, bits 1,1,0,0,0,1 -> words 3'b011 then 3'b100; the counter wraps correctly with a non-power-of-2 width.
